// File: rtl/prbs5_pkg.sv
// Shared constants and types for the PRBS-5 (x^5+x^3+1) generator/checker pair.
package prbs5_pkg;

    localparam int PRBS_W      = 5;
    localparam int TAP_A       = 2;
    localparam int TAP_B       = 4;
    localparam int PRBS_PERIOD = 31;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_e;

endpackage

// File: rtl/prbs5_step.sv
// One PRBS-5 LFSR step: feedback bit s[TAP_A]^s[TAP_B] and the shifted-in next state.
module prbs5_step
    import prbs5_pkg::*;
(
    input  logic [PRBS_W-1:0] state_i,
    output logic              fb_o,
    output logic [PRBS_W-1:0] next_o
);

    assign fb_o   = state_i[TAP_A] ^ state_i[TAP_B];
    assign next_o = {state_i[PRBS_W-2:0], fb_o};

endmodule

// File: rtl/prbs5_checker.sv
// Self-synchronising PRBS-5 receive checker with saturating error counter.
// Optional PRBS_CHK_BITCNT_EN adds a saturating count of bits checked while locked.
module prbs5_checker
    import prbs5_pkg::*;
#(
    parameter int LOCK_CNT = 8,
    parameter int LOSS_CNT = 4,
    parameter int ERR_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             din,
    input  logic             clr_cnt,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_cnt
`ifdef PRBS_CHK_BITCNT_EN
    ,
    output logic [ERR_W+8-1:0] bit_cnt
`endif
);

    localparam logic [2:0] FILL_FULL = 3'(PRBS_W);
    localparam logic [4:0] LOCK_LAST = 5'(LOCK_CNT - 1);
    localparam logic [3:0] LOSS_LAST = 4'(LOSS_CNT - 1);

    state_e             state_q;
    logic [PRBS_W-1:0]  r_q;
    logic [PRBS_W-1:0]  l_q;
    logic [2:0]         fill_q;
    logic [4:0]         match_q;
    logic [3:0]         consec_q;
    logic               locked_q;
    logic               err_pulse_q;
    logic [ERR_W-1:0]   err_cnt_q;

    logic               pred_bit;
    logic               exp_bit;
    logic [PRBS_W-1:0]  r_d;
    logic [PRBS_W-1:0]  l_d;
    logic [PRBS_W-1:0]  unused_pred_next;

    // r predicts from received history; l free-runs once locked and never sees din.
    prbs5_step u_pred_step (
        .state_i (r_q),
        .fb_o    (pred_bit),
        .next_o  (unused_pred_next)
    );

    prbs5_step u_ref_step (
        .state_i (l_q),
        .fb_o    (exp_bit),
        .next_o  (l_d)
    );

    assign r_d = {r_q[PRBS_W-2:0], din};

`ifdef PRBS_CHK_BITCNT_EN
    logic [ERR_W+8-1:0] bit_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt_q <= '0;
        end else if (en) begin
            if (clr_cnt) begin
                bit_cnt_q <= '0;
            end else if (state_q == LOCKED && bit_cnt_q != '1) begin
                bit_cnt_q <= bit_cnt_q + 1'b1;
            end
        end
    end

    assign bit_cnt = bit_cnt_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= SEARCH;
            r_q         <= '0;
            l_q         <= '0;
            fill_q      <= '0;
            match_q     <= '0;
            consec_q    <= '0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            err_pulse_q <= 1'b0;
            if (en) begin
                r_q <= r_d;
                case (state_q)
                    SEARCH: begin
                        if (fill_q != FILL_FULL) begin
                            fill_q <= fill_q + 3'd1;
                        end else if (din == pred_bit && r_q != '0) begin
                            // An all-zero history is a stuck line, never a valid lock.
                            if (match_q == LOCK_LAST) begin
                                state_q  <= LOCKED;
                                locked_q <= 1'b1;
                                l_q      <= r_d;
                                match_q  <= '0;
                                consec_q <= '0;
                            end else begin
                                match_q <= match_q + 5'd1;
                            end
                        end else begin
                            match_q <= '0;
                        end
                    end
                    LOCKED: begin
                        l_q <= l_d;
                        if (din != exp_bit) begin
                            err_pulse_q <= 1'b1;
                            if (err_cnt_q != '1) begin
                                err_cnt_q <= err_cnt_q + 1'b1;
                            end
                            if (consec_q == LOSS_LAST) begin
                                state_q  <= SEARCH;
                                locked_q <= 1'b0;
                                fill_q   <= '0;
                                match_q  <= '0;
                                consec_q <= '0;
                            end else begin
                                consec_q <= consec_q + 4'd1;
                            end
                        end else begin
                            consec_q <= '0;
                        end
                    end
                    default: state_q <= SEARCH;
                endcase
                // Clear wins over a same-cycle error; the pulse above still fires.
                if (clr_cnt) begin
                    err_cnt_q <= '0;
                end
            end
        end
    end

    assign locked    = locked_q;
    assign err_pulse = err_pulse_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: doc/prbs5_checker.md
Name: prbs5_checker

Overview:
Receive-side partner of the 5-bit PRSG.
- Consumes the serial PRBS-5 stream (polynomial x^5+x^3+1, feedback = s[2]^s[4], period 31) one bit per enable strobe.
- Self-synchronises to the stream and declares lock, then free-runs a local reference and counts bit errors.
- Sits at the far end of the link, clocked in the same domain as the generator, with `en` driven by the shared clock-divider tick.

Parameters:
- LOCK_CNT, 8: consecutive correct predictions in SEARCH required to declare lock (1..31).
- LOSS_CNT, 4: consecutive mismatches in LOCKED that drop lock (1..15).
- ERR_W, 16: width of the saturating error counter.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- en  in  1  bit strobe; all state advances only on clk edges with en=1
- din  in  1  received serial bit; the transmitted bit is the generator feedback bit s[2]^s[4]
- clr_cnt  in  1  synchronous clear of err_cnt (and bit_cnt if compiled in)
- locked  out  1  registered; 1 while in LOCKED
- err_pulse  out  1  registered; 1 for exactly one clk after an en-cycle with an error in LOCKED
- err_cnt  out  ERR_W  registered saturating error count

Behaviour:
- Reset (rst=1 at posedge) values:
  - state=SEARCH, shift reg r=0, fill=0, match=0, consec=0.
  - Local LFSR l=0.
  - locked=0, err_pulse=0, err_cnt=0.
  - rst overrides en and clr_cnt.
  - Reset mid-lock returns to SEARCH with all counters cleared on the next edge.
- When en=0, every register holds, except that err_pulse returns to 0.
- r <= {r[3:0], din} on every en cycle, in all states.
- SEARCH:
  - While fill<5, increment fill and do no comparison.
  - Once fill==5, predicted bit p = r[2]^r[4], using r before the shift.
  - If din==p and r!=5'b0, match++; otherwise match=0.
  - The all-zero condition must never count towards lock.
  - When match reaches LOCK_CNT: go to LOCKED, set locked=1 on that edge, and load l <= {r[3:0], din}, the same value r takes.
  - With LOCK_CNT=8 and fill from reset, locked rises on the edge of the 13th en strobe.
- LOCKED:
  - Expected bit e = l[2]^l[4]; l <= {l[3:0], e}. l ignores din.
  - If din!=e: err_pulse=1 next clk, err_cnt++ (saturating at all-ones), consec++.
  - If din==e: consec=0.
  - When consec reaches LOSS_CNT: go to SEARCH, locked=0 on that edge, fill=0, match=0, consec=0. The LOSS_CNT-th error is itself still counted.
- err_cnt:
  - Counts only in LOCKED and never wraps.
  - clr_cnt=1 forces 0 and wins over a simultaneous error; that error is lost but err_pulse still fires.
- Latency: din sampled at en edge N produces err_pulse during the cycle after edge N.

Optional Feature:
- Macro PRBS_CHK_BITCNT_EN.
- When defined, adds output `bit_cnt` [ERR_W+8-1:0]:
  - increments on every en cycle while LOCKED, saturating;
  - cleared by rst and clr_cnt;
  - the bench computes BER as err_cnt/bit_cnt.
- When undefined, the port and counter do not exist and behaviour is otherwise identical.

Decomposition:
- Package prbs5_pkg:
  - PRBS_W=5 and tap constants TAP_A=2, TAP_B=4;
  - state enum {SEARCH, LOCKED};
  - PRBS_PERIOD=31.
- One sub-module, prbs5_step:
  - combinational: given the 5-bit state it returns the feedback bit and next state;
  - instantiated for both the r predictor and the l reference;
  - reusable by the generator side.

Test Plan:
- Generator seeded 5'b11111, en every cycle, LOCK_CNT=8 -> locked=1 after the 13th strobe edge; err_cnt stays 0 over 1000 bits.
- After lock, invert one din bit -> exactly one err_pulse, err_cnt=1, locked stays 1, no further errors (local reference does not propagate the error).
- After lock, invert 4 consecutive bits (LOSS_CNT=4) -> err_cnt=4, locked=0 on the 4th error edge; clean stream resumes -> relock 13 strobes later.
- din held 0 for 200 strobes -> locked never asserts, err_cnt=0.
- en toggling every 3rd cycle with random stalls -> identical lock timing in strobe units; outputs frozen between strobes; err_pulse never longer than 1 clk.
- ERR_W=4, 20 isolated single-bit errors spaced 10 bits apart -> err_cnt saturates at 15. Then clr_cnt coincident with an error -> err_cnt=0, err_pulse=1. rst asserted while LOCKED -> locked=0 and err_cnt=0 next edge.
